asynfifo_flow_monitor: RTL and testbench

//  Parametrised overflow/underflow monitor for the per-port async FIFOs (host + Pn, rx and tx).

---
 rtl/asynfifo_flow_monitor_if.sv | 40 ++++
 rtl/asynfifo_flow_monitor.sv | 153 +++++++++++++++
 tb/tb_asynfifo_flow_monitor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/asynfifo_flow_monitor_if.sv
// Event inputs, clear/read controls and status outputs of the async FIFO flow monitor.
// master drives events and read requests; slave is the monitor itself.
interface asynfifo_flow_monitor_if #(
    parameter int NUM_CH = 9,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] i_rx_ovf_pulse;
    logic [NUM_CH-1:0] i_rx_udf_pulse;
    logic [NUM_CH-1:0] i_tx_ovf_pulse;
    logic              i_clear;
    logic              i_rd_req;
    logic [CH_W-1:0]   i_rd_sel;
    logic              o_rd_valid;
    logic [CNT_W-1:0]  o_rd_rx_ovf_cnt;
    logic [CNT_W-1:0]  o_rd_rx_udf_cnt;
    logic [CNT_W-1:0]  o_rd_tx_ovf_cnt;
    logic [NUM_CH-1:0] o_rx_ovf_sticky;
    logic [NUM_CH-1:0] o_rx_udf_sticky;
    logic [NUM_CH-1:0] o_tx_ovf_sticky;
    logic              o_rx_ovf_led;
    logic              o_rx_udf_led;
    logic              o_tx_ovf_led;

    modport master (
        output i_rx_ovf_pulse, i_rx_udf_pulse, i_tx_ovf_pulse,
        output i_clear, i_rd_req, i_rd_sel,
        input  o_rd_valid, o_rd_rx_ovf_cnt, o_rd_rx_udf_cnt, o_rd_tx_ovf_cnt,
        input  o_rx_ovf_sticky, o_rx_udf_sticky, o_tx_ovf_sticky,
        input  o_rx_ovf_led, o_rx_udf_led, o_tx_ovf_led
    );

    modport slave (
        input  i_rx_ovf_pulse, i_rx_udf_pulse, i_tx_ovf_pulse,
        input  i_clear, i_rd_req, i_rd_sel,
        output o_rd_valid, o_rd_rx_ovf_cnt, o_rd_rx_udf_cnt, o_rd_tx_ovf_cnt,
        output o_rx_ovf_sticky, o_rx_udf_sticky, o_tx_ovf_sticky,
        output o_rx_ovf_led, o_rx_udf_led, o_tx_ovf_led
    );
endinterface

// File: rtl/asynfifo_flow_monitor.sv
// Per-channel async FIFO overflow/underflow monitor: sticky flags, saturating counters, stretched LEDs.
// Latency: sync events visible 1 cycle later, async rx overflow 3 cycles later; reads return 1 cycle later.
// Backpressure: none; every rising edge is accepted every cycle, reads are single-cycle strobes.
module asynfifo_flow_monitor #(
    parameter int                NUM_CH      = 9,
    parameter int                CNT_W       = 16,
    parameter int                LED_HOLD    = 125000,
    parameter logic [NUM_CH-1:0] RXOVF_ASYNC = {NUM_CH{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    asynfifo_flow_monitor_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = $clog2(LED_HOLD + 1);

    logic [NUM_CH-1:0] rx_ovf_d, rx_ovf_s1, rx_ovf_s2, rx_ovf_s3;
    logic [NUM_CH-1:0] rx_udf_d, tx_ovf_d;
    logic [NUM_CH-1:0] rx_ovf_ev, rx_udf_ev, tx_ovf_ev;

    logic [NUM_CH-1:0][CNT_W-1:0] rx_ovf_cnt, rx_udf_cnt, tx_ovf_cnt;
    logic [NUM_CH-1:0]            rx_ovf_sticky, rx_udf_sticky, tx_ovf_sticky;

    logic [2:0][TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]            any_ev, led_q;

    logic [CH_W-1:0]  rd_sel;
    logic [CNT_W-1:0] rd_rx_ovf, rd_rx_udf, rd_tx_ovf;
    logic [CNT_W-1:0] rd_rx_ovf_q, rd_rx_udf_q, rd_tx_ovf_q;
    logic             rd_valid_q;

    assign rd_sel = bus.i_rd_sel;

    // Delay and synchroniser registers; s1 is the metastability-absorbing stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_ovf_d  <= '0;
            rx_ovf_s1 <= '0;
            rx_ovf_s2 <= '0;
            rx_ovf_s3 <= '0;
            rx_udf_d  <= '0;
            tx_ovf_d  <= '0;
        end else begin
            rx_ovf_d  <= bus.i_rx_ovf_pulse;
            rx_ovf_s1 <= bus.i_rx_ovf_pulse;
            rx_ovf_s2 <= rx_ovf_s1;
            rx_ovf_s3 <= rx_ovf_s2;
            rx_udf_d  <= bus.i_rx_udf_pulse;
            tx_ovf_d  <= bus.i_tx_ovf_pulse;
        end
    end

    // Per-bit choice between the synchronised and the direct edge detector.
    assign rx_ovf_ev = (RXOVF_ASYNC & rx_ovf_s2 & ~rx_ovf_s3)
                     | (~RXOVF_ASYNC & bus.i_rx_ovf_pulse & ~rx_ovf_d);
    assign rx_udf_ev = bus.i_rx_udf_pulse & ~rx_udf_d;
    assign tx_ovf_ev = bus.i_tx_ovf_pulse & ~tx_ovf_d;

    // Clear takes effect first so an edge in the clear cycle still counts.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic hit, input logic clr);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != '1)) base = base + CNT_W'(1);
        return base;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_ovf_cnt    <= '0;
            rx_udf_cnt    <= '0;
            tx_ovf_cnt    <= '0;
            rx_ovf_sticky <= '0;
            rx_udf_sticky <= '0;
            tx_ovf_sticky <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                rx_ovf_cnt[k] <= cnt_next(rx_ovf_cnt[k], rx_ovf_ev[k], bus.i_clear);
                rx_udf_cnt[k] <= cnt_next(rx_udf_cnt[k], rx_udf_ev[k], bus.i_clear);
                tx_ovf_cnt[k] <= cnt_next(tx_ovf_cnt[k], tx_ovf_ev[k], bus.i_clear);
            end
            rx_ovf_sticky <= (bus.i_clear ? '0 : rx_ovf_sticky) | rx_ovf_ev;
            rx_udf_sticky <= (bus.i_clear ? '0 : rx_udf_sticky) | rx_udf_ev;
            tx_ovf_sticky <= (bus.i_clear ? '0 : tx_ovf_sticky) | tx_ovf_ev;
        end
    end

    assign any_ev = {|tx_ovf_ev, |rx_udf_ev, |rx_ovf_ev};

    always_comb begin
        tmr_d = tmr_q;
        for (int t = 0; t < 3; t++) begin
            if (any_ev[t]) begin
                tmr_d[t] = TMR_W'(LED_HOLD);
            end else if (tmr_q[t] != '0) begin
                tmr_d[t] = tmr_q[t] - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmr_q <= '0;
            led_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            for (int t = 0; t < 3; t++) begin
                led_q[t] <= (tmr_d[t] != '0);
            end
        end
    end

    // Out-of-range selects fall through to zero counts.
    always_comb begin
        rd_rx_ovf = '0;
        rd_rx_udf = '0;
        rd_tx_ovf = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (32'(rd_sel) == k) begin
                rd_rx_ovf = rx_ovf_cnt[k];
                rd_rx_udf = rx_udf_cnt[k];
                rd_tx_ovf = tx_ovf_cnt[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_rx_ovf_q <= '0;
            rd_rx_udf_q <= '0;
            rd_tx_ovf_q <= '0;
        end else begin
            rd_valid_q <= bus.i_rd_req;
            if (bus.i_rd_req) begin
                rd_rx_ovf_q <= rd_rx_ovf;
                rd_rx_udf_q <= rd_rx_udf;
                rd_tx_ovf_q <= rd_tx_ovf;
            end
        end
    end

    assign bus.o_rd_valid      = rd_valid_q;
    assign bus.o_rd_rx_ovf_cnt = rd_rx_ovf_q;
    assign bus.o_rd_rx_udf_cnt = rd_rx_udf_q;
    assign bus.o_rd_tx_ovf_cnt = rd_tx_ovf_q;
    assign bus.o_rx_ovf_sticky = rx_ovf_sticky;
    assign bus.o_rx_udf_sticky = rx_udf_sticky;
    assign bus.o_tx_ovf_sticky = tx_ovf_sticky;
    assign bus.o_rx_ovf_led    = led_q[0];
    assign bus.o_rx_udf_led    = led_q[1];
    assign bus.o_tx_ovf_led    = led_q[2];
endmodule

// File: tb/tb_asynfifo_flow_monitor.sv
// Bench for asynfifo_flow_monitor: directed scenarios plus random traffic against an event-level model.
module tb_asynfifo_flow_monitor;
    localparam int NUM_CH   = 9;
    localparam int CNT_W    = 4;
    localparam int LED_HOLD = 8;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    asynfifo_flow_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    asynfifo_flow_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LED_HOLD(LED_HOLD)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: index 0 = rx overflow (async), 1 = rx underflow, 2 = tx overflow.
    int                m_cnt    [3][NUM_CH];
    logic [NUM_CH-1:0] m_sticky [3];
    logic [NUM_CH-1:0] m_prev   [3];
    logic [NUM_CH-1:0] m_dly    [2];
    int                m_last   [3];
    bit                m_has    [3];
    int                m_rd     [3];
    bit                m_vld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < NUM_CH; k++) m_cnt[t][k] = 0;
            m_sticky[t] = '0;
            m_prev[t]   = '0;
            m_has[t]    = 1'b0;
            m_last[t]   = 0;
            m_rd[t]     = 0;
        end
        m_dly[0] = '0;
        m_dly[1] = '0;
        m_vld    = 1'b0;
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] raw [3];
        logic [NUM_CH-1:0] ev  [3];
        raw[0] = bus.i_rx_ovf_pulse;
        raw[1] = bus.i_rx_udf_pulse;
        raw[2] = bus.i_tx_ovf_pulse;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        // Async rx overflow edges surface two cycles after the sync-domain ones.
        ev[0]    = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = raw[0] & ~m_prev[0];
        ev[1]    = raw[1] & ~m_prev[1];
        ev[2]    = raw[2] & ~m_prev[2];
        for (int t = 0; t < 3; t++) m_prev[t] = raw[t];
        m_vld = bus.i_rd_req;
        if (bus.i_rd_req) begin
            for (int t = 0; t < 3; t++) begin
                if (int'(bus.i_rd_sel) < NUM_CH) m_rd[t] = m_cnt[t][bus.i_rd_sel];
                else                             m_rd[t] = 0;
            end
        end
        if (bus.i_clear) begin
            for (int t = 0; t < 3; t++) begin
                m_sticky[t] = '0;
                for (int k = 0; k < NUM_CH; k++) m_cnt[t][k] = 0;
            end
        end
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ev[t][k]) begin
                    if (m_cnt[t][k] < CMAX) m_cnt[t][k]++;
                    m_sticky[t][k] = 1'b1;
                    m_last[t]      = cyc;
                    m_has[t]       = 1'b1;
                end
            end
        end
    endtask

    function automatic bit led_exp(input int t);
        return m_has[t] && ((cyc - m_last[t]) < LED_HOLD);
    endfunction

    task automatic check_all();
        chk("rx_ovf_sticky", bus.o_rx_ovf_sticky, m_sticky[0]);
        chk("rx_udf_sticky", bus.o_rx_udf_sticky, m_sticky[1]);
        chk("tx_ovf_sticky", bus.o_tx_ovf_sticky, m_sticky[2]);
        chk("rx_ovf_led", bus.o_rx_ovf_led, led_exp(0));
        chk("rx_udf_led", bus.o_rx_udf_led, led_exp(1));
        chk("tx_ovf_led", bus.o_tx_ovf_led, led_exp(2));
        chk("rd_valid", bus.o_rd_valid, m_vld);
        chk("rd_rx_ovf", bus.o_rd_rx_ovf_cnt, m_rd[0]);
        chk("rd_rx_udf", bus.o_rd_rx_udf_cnt, m_rd[1]);
        chk("rd_tx_ovf", bus.o_rd_tx_ovf_cnt, m_rd[2]);
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.i_rx_ovf_pulse = '0;
        bus.i_rx_udf_pulse = '0;
        bus.i_tx_ovf_pulse = '0;
        bus.i_clear        = 1'b0;
        bus.i_rd_req       = 1'b0;
        bus.i_rd_sel       = '0;
    endtask

    task automatic read_ch(input int sel, input int e_rxo, input int e_rxu, input int e_txo,
                           input string tag);
        bus.i_rd_sel = 4'(sel);
        bus.i_rd_req = 1'b1;
        tick();
        bus.i_rd_req = 1'b0;
        chk({tag, "_vld"}, bus.o_rd_valid, 1);
        chk({tag, "_rxo"}, bus.o_rd_rx_ovf_cnt, e_rxo);
        chk({tag, "_rxu"}, bus.o_rd_rx_udf_cnt, e_rxu);
        chk({tag, "_txo"}, bus.o_rd_tx_ovf_cnt, e_txo);
    endtask

    logic [NUM_CH-1:0] rx_cur;
    int                rx_run [NUM_CH];

    initial begin
        model_reset();
        idle_inputs();
        i_rst_n = 1'b0;

        // Reset and idle
        repeat (3) tick();
        i_rst_n = 1'b1;
        chk("rst_sticky", {bus.o_rx_ovf_sticky, bus.o_rx_udf_sticky, bus.o_tx_ovf_sticky}, 0);
        chk("rst_led", {bus.o_rx_ovf_led, bus.o_rx_udf_led, bus.o_tx_ovf_led}, 0);
        chk("rst_rd", {bus.o_rd_valid, bus.o_rd_rx_ovf_cnt, bus.o_rd_rx_udf_cnt,
                       bus.o_rd_tx_ovf_cnt}, 0);
        repeat (20) tick();
        chk("idle_all", {bus.o_rx_ovf_sticky, bus.o_rx_udf_sticky, bus.o_tx_ovf_sticky,
                         bus.o_rx_ovf_led, bus.o_rx_udf_led, bus.o_tx_ovf_led, bus.o_rd_valid}, 0);

        // Single sync event and LED stretch
        bus.i_tx_ovf_pulse[3] = 1'b1;
        tick();
        bus.i_tx_ovf_pulse[3] = 1'b0;
        chk("sync_sticky", bus.o_tx_ovf_sticky, 9'h008);
        chk("sync_led_on", bus.o_tx_ovf_led, 1);
        repeat (7) tick();
        chk("sync_led_n8", bus.o_tx_ovf_led, 1);
        tick();
        chk("sync_led_n9", bus.o_tx_ovf_led, 0);
        read_ch(3, 0, 0, 1, "sync_rd");

        // Async input held 5 cycles
        bus.i_rx_ovf_pulse[0] = 1'b1;
        tick();
        tick();
        chk("async_n2", bus.o_rx_ovf_sticky[0], 0);
        tick();
        chk("async_n3", bus.o_rx_ovf_sticky[0], 1);
        repeat (2) tick();
        bus.i_rx_ovf_pulse[0] = 1'b0;
        repeat (5) tick();
        read_ch(0, 1, 0, 0, "async_rd");

        // Saturation
        for (int i = 0; i < 20; i++) begin
            bus.i_rx_udf_pulse[8] = 1'b1;
            tick();
            bus.i_rx_udf_pulse[8] = 1'b0;
            tick();
        end
        read_ch(8, 0, 15, 0, "sat_rd");

        // Clear colliding with an edge
        for (int i = 0; i < 3; i++) begin
            bus.i_rx_udf_pulse[2] = 1'b1;
            tick();
            bus.i_rx_udf_pulse[2] = 1'b0;
            tick();
        end
        read_ch(2, 0, 3, 0, "pre_clr_rd");
        bus.i_clear           = 1'b1;
        bus.i_rx_udf_pulse[2] = 1'b1;
        tick();
        bus.i_clear           = 1'b0;
        bus.i_rx_udf_pulse[2] = 1'b0;
        chk("clr_udf_sticky", bus.o_rx_udf_sticky, 9'h004);
        chk("clr_rxo_sticky", bus.o_rx_ovf_sticky, 0);
        chk("clr_txo_sticky", bus.o_tx_ovf_sticky, 0);
        read_ch(2, 0, 1, 0, "clr_rd2");
        read_ch(8, 0, 0, 0, "clr_rd8");
        read_ch(3, 0, 0, 0, "clr_rd3");

        // LED retrigger
        repeat (20) tick();
        bus.i_tx_ovf_pulse[5] = 1'b1;
        tick();
        bus.i_tx_ovf_pulse[5] = 1'b0;
        repeat (4) tick();
        bus.i_tx_ovf_pulse[5] = 1'b1;
        tick();
        bus.i_tx_ovf_pulse[5] = 1'b0;
        repeat (3) tick();
        chk("retrig_n9", bus.o_tx_ovf_led, 1);
        repeat (4) tick();
        chk("retrig_n13", bus.o_tx_ovf_led, 1);
        tick();
        chk("retrig_n14", bus.o_tx_ovf_led, 0);
        read_ch(5, 0, 0, 2, "retrig_rd");

        // Out-of-range select
        read_ch(12, 0, 0, 0, "badsel_rd");
        tick();
        chk("badsel_vld_drop", bus.o_rd_valid, 0);

        // Random traffic, with one reset in the middle
        rx_cur = '0;
        for (int k = 0; k < NUM_CH; k++) rx_run[k] = 2;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rx_run[k] >= 2 && $urandom_range(0, 3) == 0) begin
                    rx_cur[k] = ~rx_cur[k];
                    rx_run[k] = 1;
                end else begin
                    rx_run[k]++;
                end
            end
            bus.i_rx_ovf_pulse = rx_cur;
            for (int k = 0; k < NUM_CH; k++) begin
                bus.i_rx_udf_pulse[k] = ($urandom_range(0, 3) == 0);
                bus.i_tx_ovf_pulse[k] = ($urandom_range(0, 4) == 0);
            end
            bus.i_clear  = ($urandom_range(0, 39) == 0);
            bus.i_rd_req = ($urandom_range(0, 2) == 0);
            bus.i_rd_sel = 4'($urandom_range(0, 15));
            i_rst_n      = !(i >= 1500 && i < 1503);
            tick();
        end
        i_rst_n = 1'b1;
        idle_inputs();
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
